// File: rtl/mssd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mssd_pkg
// Purpose  : Shared definitions for the multi-channel synchronous serial link
//            (transmit framer and receive demux). Holds the frame state
//            encoding, the start pattern, default field widths and the
//            channel count.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mssd_pkg;

  localparam int NUM_CH     = 4;
  localparam int CH_W       = 2;   // width of the destination field
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 4;
  localparam int START_W    = 4;

  localparam logic [START_W-1:0] START_PAT = 4'b0110;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DEST  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4,
    GAP   = 3'd5
  } state_e;

  // One-hot channel vector from a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mssd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mssd_rr_arbiter
// Purpose  : Round-robin arbiter for the framer channels. The grant is
//            combinational from req and the pointer; the pointer moves to
//            (winner + 1) mod NUM_CH only when the grant is actually taken.
// Ports    : clk       - rising-edge clock
//            reset     - asynchronous active-low reset (pointer -> 0)
//            req       - per-channel request levels
//            grant_en  - caller is able to accept a grant this cycle
//            grant_vld - at least one channel is requesting
//            grant_idx - index of the winning channel
// Revision : 1.0 - initial release
// ============================================================================
module mssd_rr_arbiter
  import mssd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              grant_en,
  output logic              grant_vld,
  output logic [CH_W-1:0]   grant_idx
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so that the channel
  // closest to the pointer (upward, wrapping) is the last one written and
  // therefore wins. NUM_CH is a power of two, so the index wraps naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = ptr_q + CH_W'(off);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en && grant_vld) begin
      ptr_d = grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mssd_framer_tx.sv
`default_nettype none
// ============================================================================
// Module   : mssd_framer_tx
// Purpose  : Transmit framer. Arbitrates round-robin between four channels
//            and serializes the granted payload as
//              START_PAT (MSB first), dest (MSB first), len (MSB first),
//              data bit 0 .. bit len (LSB first), then one gap cycle.
// Ports    : clk     - rising-edge clock
//            reset   - asynchronous active-low reset
//            req     - per-channel request level, held until ack
//            dataIn  - channel k payload in [k*DATA_W +: DATA_W]
//            lenIn   - channel k length-1 in [k*LEN_W +: LEN_W]
//            ack     - one-cycle one-hot grant pulse (payload latched)
//            serOut  - serial frame output, 0 when idle
//            dataCom - high during data-bit cycles of serOut
//            busy    - high from first start bit through the gap cycle
// Notes    : DATA_W must be at least 2**LEN_W.
// Revision : 1.0 - initial release
// ============================================================================
module mssd_framer_tx
  import mssd_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 LEN_W     = DEF_LEN_W,
  parameter logic [START_W-1:0] START_PAT = mssd_pkg::START_PAT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*DATA_W-1:0] dataIn,
  input  logic [NUM_CH*LEN_W-1:0]  lenIn,
  output logic [NUM_CH-1:0]        ack,
  output logic                     serOut,
  output logic                     dataCom,
  output logic                     busy
);

  localparam int HDR_W = START_W + CH_W + LEN_W;
  // One bit wider than len so counting to len = 2**LEN_W-1 never wraps.
  localparam int CNT_W = LEN_W + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_W-1:0]    hdr_q, hdr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                ser_q, ser_d;
  logic                dcom_q, dcom_d;
  logic                busy_q, busy_d;

  logic                grant_en;
  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic [LEN_W-1:0]    sel_len;
  logic [HDR_W-1:0]    hdr_shift;

  // Only the IDLE state may accept a grant; requests during a frame wait.
  assign grant_en = (state_q == IDLE);

  mssd_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .grant_en  (grant_en),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Payload / length select for the winning channel.
  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_W'(i)) begin
        sel_data = dataIn[i*DATA_W +: DATA_W];
        sel_len  = lenIn[i*LEN_W +: LEN_W];
      end
    end
  end

  // The whole header (pattern, dest, len) is loaded into one register at
  // grant and shifted left once per header cycle; its MSB is the next bit.
  // Data is shifted right once per data cycle so bit 1 is always the next
  // data bit. The per-state counter only decides when each field ends.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    data_d    = data_q;
    len_d     = len_q;
    ack_d     = '0;
    ser_d     = 1'b0;
    dcom_d    = 1'b0;
    busy_d    = 1'b1;
    hdr_shift = hdr_q << 1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (grant_vld) begin
          state_d = START;
          cnt_d   = '0;
          hdr_d   = {START_PAT, grant_idx, sel_len};
          data_d  = sel_data;
          len_d   = sel_len;
          ack_d   = ch_onehot(grant_idx);
          ser_d   = START_PAT[START_W-1];
          busy_d  = 1'b1;
        end
      end

      START: begin
        hdr_d = hdr_shift;
        ser_d = hdr_shift[HDR_W-1];
        if (cnt_q == CNT_W'(START_W - 1)) begin
          state_d = DEST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DEST: begin
        hdr_d = hdr_shift;
        ser_d = hdr_shift[HDR_W-1];
        if (cnt_q == CNT_W'(CH_W - 1)) begin
          state_d = LEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LEN: begin
        hdr_d = hdr_shift;
        if (cnt_q == CNT_W'(LEN_W - 1)) begin
          state_d = DATA;
          cnt_d   = '0;
          ser_d   = data_q[0];
          dcom_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          ser_d = hdr_shift[HDR_W-1];
        end
      end

      DATA: begin
        if (cnt_q == {1'b0, len_q}) begin
          // Last data bit shown; the gap cycle drives 0 with busy still high.
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          data_d = data_q >> 1;
          ser_d  = data_q[1];
          dcom_d = 1'b1;
        end
      end

      GAP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hdr_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      ack_q   <= '0;
      ser_q   <= 1'b0;
      dcom_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      ser_q   <= ser_d;
      dcom_q  <= dcom_d;
      busy_q  <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign serOut  = ser_q;
  assign dataCom = dcom_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire
